pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Sits directly downstream of the ECP5 PLL wrapper and consumes its `locked` output.
- Runs in the PLL output clock domain (40 MHz).
- Produces staged, synchronous reset releases for the SoC fabric and the CPU core.
- Re-asserts both resets on PLL lock loss, supports a software-requested CPU-only reset, and keeps a saturating count of lock-loss events for debug CSRs.

Parameters:
- SYNC_STAGES, 2: flops in the pll_locked synchronizer (≥2).
- LOCK_STABLE_CYCLES, 4096: consecutive synchronized-locked cycles required before releasing soc_rst (≥1; about 102 µs at 40 MHz).
- CPU_DELAY_CYCLES, 16: cycles between soc_rst release and cpu_rst release; also the CPU soft-reset hold length (≥1).

Ports:
- clk, input, 1: PLL clkout0, 40 MHz.
- rst, input, 1: synchronous, active-high reset (external button, already synchronized to clk).
- pll_locked, input, 1: PLL lock indicator, treated as asynchronous.
- soft_rst_req, input, 1: single-cycle request from SoC to reset the CPU only.
- soc_rst, output, 1: active-high reset to peripherals, bus and memories.
- cpu_rst, output, 1: active-high reset to the CPU core.
- ready, output, 1: high only in RUN.
- lock_loss_count, output, 8: number of lock losses seen from PERIPH or RUN; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - state = WAIT_LOCK, cnt = 0, all synchronizer flops 0.
  - soc_rst = 1, cpu_rst = 1, ready = 0, lock_loss_count = 0.
- Synchronizer: pll_locked passes through SYNC_STAGES flops to give lock_s. No other logic samples pll_locked directly.
- Counter: cnt is a single shared counter, width clog2(max(LOCK_STABLE_CYCLES, CPU_DELAY_CYCLES)). It is cleared on every state entry.
- Outputs are registered and update on the same edge as the state change:
  - soc_rst = 1 in WAIT_LOCK and STABLE.
  - cpu_rst = 1 in every state except RUN.
  - ready = 1 only in RUN.
- State WAIT_LOCK:
  - lock_s = 1 → STABLE, cnt = 0.
- State STABLE:
  - lock_s = 0 → WAIT_LOCK. This is a glitch during lock acquisition and is not counted.
  - lock_s = 1 and cnt == LOCK_STABLE_CYCLES-1 → PERIPH.
  - Otherwise cnt increments.
- State PERIPH:
  - lock_s = 0 → WAIT_LOCK and lock_loss_count increments.
  - cnt == CPU_DELAY_CYCLES-1 → RUN.
  - Otherwise cnt increments.
  - soft_rst_req is ignored.
- State RUN:
  - lock_s = 0 → WAIT_LOCK and lock_loss_count increments.
  - soft_rst_req = 1 → PERIPH with cnt = 0. cpu_rst re-asserts and ready falls on that edge; soc_rst stays 0.
- Simultaneous events:
  - Lock loss and soft_rst_req in the same cycle: lock loss wins, and the request is dropped.
  - rst during any state: immediate return to reset values, including clearing lock_loss_count.
- Saturation: lock_loss_count holds at 255 and does not wrap.
- Timing: edge 0 is the first rising edge that samples pll_locked = 1, with pll_locked held high afterwards.
  - soc_rst falls at edge SYNC_STAGES + LOCK_STABLE_CYCLES.
  - cpu_rst falls and ready rises exactly CPU_DELAY_CYCLES edges later.
- Ordering invariants:
  - cpu_rst is never 0 while soc_rst is 1.
  - ready equals the inverse of cpu_rst, and ready implies not soc_rst.
- Lock loss is detected SYNC_STAGES edges after pll_locked falls. Both resets assert on the following edge.

Test Plan (all scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, CPU_DELAY_CYCLES=4):
1. Power-up:
   - Stimulus: rst high 3 cycles, then low; pll_locked rises and stays high.
   - Required: soc_rst falls at edge 10, cpu_rst falls and ready rises at edge 14.
   - Required: lock_loss_count = 0 throughout.
2. Lock glitch during acquisition:
   - Stimulus: pll_locked high 5 cycles, low 1 cycle, then high.
   - Required: soc_rst stays 1 through the glitch and falls 10 edges after the second rise.
   - Required: lock_loss_count stays 0.
3. Lock loss in RUN:
   - Stimulus: drop pll_locked for 3 cycles while in RUN.
   - Required: soc_rst, cpu_rst → 1 and ready → 0 three edges after the drop; lock_loss_count = 1.
   - Required: full re-release sequence (10 + 4 edges) after lock returns.
4. Soft reset:
   - Stimulus: 1-cycle soft_rst_req in RUN.
   - Required: cpu_rst = 1 for exactly 4 cycles; soc_rst stays 0; ready is low for the same 4 cycles.
   - Stimulus: soft_rst_req pulse in STABLE.
   - Required: no effect.
5. Collision:
   - Stimulus: soft_rst_req on the same edge lock_s falls in RUN.
   - Required: state goes to WAIT_LOCK, soc_rst = 1, lock_loss_count increments by 1.
6. Saturation and reset:
   - Stimulus: force 260 lock losses from RUN.
   - Required: lock_loss_count = 255.
   - Stimulus: assert rst mid-PERIPH.
   - Required: next edge shows soc_rst = 1, cpu_rst = 1, ready = 0, count = 0.

Source files
------------

// File: rtl/pll_reset_seq.sv
// Staged SoC/CPU reset release behind the PLL lock indicator, with lock-loss re-assertion,
// CPU-only soft reset and a saturating lock-loss counter.
//
// state     | meaning
// WAIT_LOCK | PLL not locked; SoC and CPU held in reset
// STABLE    | lock seen; counting LOCK_STABLE_CYCLES of continuous lock
// PERIPH    | SoC released; CPU held for CPU_DELAY_CYCLES
// RUN       | both released; ready high
module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 4096,
    parameter int CPU_DELAY_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       soc_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > CPU_DELAY_CYCLES) ?
                             LOCK_STABLE_CYCLES : CPU_DELAY_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(CPU_DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        PERIPH    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   loss_inc;

    // pll_locked is asynchronous to clk; nothing else may look at it directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        loss_inc  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) begin
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                // A drop here is an acquisition glitch, not a counted loss.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = PERIPH;
                    cnt_nxt   = '0;
                end
            end
            PERIPH: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    loss_inc  = 1'b1;
                end else if (cnt == DELAY_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                // Lock loss takes priority; a coincident soft request is dropped.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    loss_inc  = 1'b1;
                end else if (soft_rst_req) begin
                    state_nxt = PERIPH;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            soc_rst         <= 1'b1;
            cpu_rst         <= 1'b1;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            soc_rst <= (state_nxt == WAIT_LOCK) || (state_nxt == STABLE);
            cpu_rst <= (state_nxt != RUN);
            ready   <= (state_nxt == RUN);
            if (loss_inc && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: power-up, acquisition glitch, lock loss, soft reset,
// collision, counter saturation and reset mid-sequence.
module tb_pll_reset_seq;

    localparam int SS    = 2;
    localparam int LS    = 8;
    localparam int CD    = 4;
    localparam int REL   = SS + LS;
    localparam int RUN_E = REL + CD;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       soc_rst;
    logic       cpu_rst;
    logic       ready;
    logic [7:0] lock_loss_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ll   = 0;

    pll_reset_seq #(
        .SYNC_STAGES       (SS),
        .LOCK_STABLE_CYCLES(LS),
        .CPU_DELAY_CYCLES  (CD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_rst_req   (soft_rst_req),
        .soc_rst        (soc_rst),
        .cpu_rst        (cpu_rst),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int s, input int c, input int r);
        check({tag, " soc_rst"}, int'(soc_rst), s);
        check({tag, " cpu_rst"}, int'(cpu_rst), c);
        check({tag, " ready"},   int'(ready),   r);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edge 0 is the first edge after this call; soft_edge pulses soft_rst_req on that edge.
    task automatic release_seq(input int soft_edge, input bit chk);
        pll_locked = 1'b1;
        for (int k = 0; k <= RUN_E; k++) begin
            soft_rst_req = (k == soft_edge);
            tick();
            soft_rst_req = 1'b0;
            if (chk) begin
                check_outs($sformatf("release e%0d", k),
                           int'(k < REL), int'(k < RUN_E), int'(k >= RUN_E));
            end
        end
        if (chk) check("release ll_count", int'(lock_loss_count), exp_ll);
    endtask

    // Starts in RUN; pll_locked is low for three sampled edges.
    task automatic drop_lock(input bit collide, input bit chk);
        pll_locked = 1'b0;
        tick();
        if (chk) check_outs("drop e1", 0, 0, 1);
        tick();
        if (chk) check_outs("drop e2", 0, 0, 1);
        soft_rst_req = collide;
        tick();
        soft_rst_req = 1'b0;
        if (exp_ll < 255) exp_ll++;
        if (chk) begin
            check_outs("drop e3", 1, 1, 0);
            check("drop ll_count", int'(lock_loss_count), exp_ll);
        end
    endtask

    task automatic soft_in_run;
        for (int j = 0; j <= CD; j++) begin
            soft_rst_req = (j == 0);
            tick();
            soft_rst_req = 1'b0;
            check_outs($sformatf("soft e%0d", j), 0, int'(j < CD), int'(j >= CD));
        end
    endtask

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        check_outs("reset", 1, 1, 0);
        check("reset ll_count", int'(lock_loss_count), 0);

        // Power-up then CPU-only soft reset.
        rst = 1'b0;
        release_seq(-1, 1'b1);
        soft_in_run();
        check("soft ll_count", int'(lock_loss_count), 0);

        // One-cycle lock glitch during acquisition.
        rst        = 1'b1;
        pll_locked = 1'b0;
        tick();
        check_outs("reset2", 1, 1, 0);
        rst        = 1'b0;
        pll_locked = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("glitch pre e%0d soc_rst", k), int'(soc_rst), 1);
        end
        pll_locked = 1'b0;
        tick();
        check_outs("glitch low", 1, 1, 0);
        release_seq(-1, 1'b1);

        // Lock loss in RUN, then collision with a soft request.
        drop_lock(1'b0, 1'b1);
        release_seq(-1, 1'b1);
        drop_lock(1'b1, 1'b1);
        release_seq(3, 1'b1);

        // Saturate the loss counter.
        for (int i = 0; i < 260; i++) begin
            drop_lock(1'b0, 1'b0);
            release_seq(-1, 1'b0);
        end
        check("saturated ll_count", int'(lock_loss_count), 255);
        check_outs("after saturation", 0, 0, 1);

        // Reset while in PERIPH.
        drop_lock(1'b0, 1'b0);
        check("still saturated", int'(lock_loss_count), 255);
        pll_locked = 1'b1;
        repeat (REL + 2) tick();
        check_outs("mid periph", 0, 1, 0);
        rst = 1'b1;
        tick();
        check_outs("rst in periph", 1, 1, 0);
        check("rst ll_count", int'(lock_loss_count), 0);
        exp_ll = 0;
        rst    = 1'b0;
        release_seq(-1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
